dmem_block_responder: RTL and testbench

- Data-memory side of the cache refill/writeback interface. It answers block requests from the cache controller.
- Serves three request types, each with a fixed, parameterised access latency:
  - block read (refill)
  - block write (dirty-victim writeback)
  - combined writeback-then-refill
- Holds the behavioural word-array backing store. Returns the whole block in one beat with a one-cycle response strobe.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_block_array.sv | 42 ++++
 rtl/dmem_block_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_block_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory block responder: state encoding,
// offset-width helpers and the block-base address function.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Widths of the byte-within-word and word-within-block offset fields.
    function automatic int byte_off_width(input int word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int block_off_width(input int block_words);
        return $clog2(block_words);
    endfunction

    // Word index of the first word of the block holding addr, wrapped into the array.
    function automatic logic [63:0] block_base(input logic [63:0] addr,
                                               input int        byte_off,
                                               input int        blk_off,
                                               input int        depth_words);
        logic [63:0] word_idx;
        word_idx = addr >> byte_off;
        word_idx = word_idx & ~((64'd1 << blk_off) - 64'd1);
        return word_idx & (64'(depth_words) - 64'd1);
    endfunction

endpackage

// File: rtl/dmem_block_array.sv
// Behavioural word array with one block-wide synchronous write port and one
// block-wide registered read port. Array contents are never reset.
module dmem_block_array
    import dmem_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_base,
    input  logic [WORD_W*BLOCK_WORDS-1:0] wr_data,
    input  logic                          rd_en,
    input  logic [IDX_W-1:0]              rd_base,
    output logic [WORD_W*BLOCK_WORDS-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Block bases are aligned, so OR-ing in the word offset never carries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem[wr_base | IDX_W'(i)] <= wr_data[i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                rd_data[i*WORD_W +: WORD_W] <= mem[rd_base | IDX_W'(i)];
            end
        end
    end

endmodule

// File: rtl/dmem_block_responder.sv
// Data-memory responder for cache refill / writeback / combined block requests.
// Optional saturating access counters are enabled with `define DMEM_PERF_CNT_EN.
module dmem_block_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rd,
    input  logic                          req_wr,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic [WORD_W*BLOCK_WORDS-1:0] wb_data,
    output logic [WORD_W*BLOCK_WORDS-1:0] rd_data,
    output logic                          rsp_valid,
    output logic                          busy,
    output logic [15:0]                   rd_cnt,
    output logic [15:0]                   wr_cnt
);

    localparam int IDX_W      = $clog2(DEPTH_WORDS);
    localparam int BYTE_OFF_W = byte_off_width(WORD_W);
    localparam int BLK_OFF_W  = block_off_width(BLOCK_WORDS);
    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_block_responder: LATENCY must be in 1..15");
        end
        if ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_block
            $error("dmem_block_responder: BLOCK_WORDS must be a power of two");
        end
        if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || (DEPTH_WORDS % BLOCK_WORDS) != 0) begin : g_bad_depth
            $error("dmem_block_responder: DEPTH_WORDS must be a power of two and a multiple of BLOCK_WORDS");
        end
    endgenerate

    logic [1:0]                    state;
    logic [3:0]                    cnt;
    logic                          rd_pend;
    logic [IDX_W-1:0]              rd_base_q;
    logic [IDX_W-1:0]              wb_base_q;
    logic [WORD_W*BLOCK_WORDS-1:0] wb_data_q;
    logic                          accept;
    logic                          cnt_last;
    logic                          wr_commit;
    logic                          rd_commit;

    assign req_ready = (state == ST_IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid & req_ready;
    assign cnt_last  = (cnt == CNT_LAST);
    assign wr_commit = (state == ST_WB) & cnt_last;
    assign rd_commit = (state == ST_RD) & cnt_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rd_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cnt     <= '0;
                        rd_pend <= req_rd;
                        if (req_wr) begin
                            state <= ST_WB;
                        end else if (req_rd) begin
                            state <= ST_RD;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WB: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= rd_pend ? ST_RD : ST_RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RD: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request payload is captured once at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_base_q <= IDX_W'(block_base(64'(rd_addr), BYTE_OFF_W, BLK_OFF_W, DEPTH_WORDS));
            wb_base_q <= IDX_W'(block_base(64'(wb_addr), BYTE_OFF_W, BLK_OFF_W, DEPTH_WORDS));
            wb_data_q <= wb_data;
        end
    end

    dmem_block_array #(
        .WORD_W     (WORD_W),
        .BLOCK_WORDS(BLOCK_WORDS),
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_commit),
        .wr_base(wb_base_q),
        .wr_data(wb_data_q),
        .rd_en  (rd_commit),
        .rd_base(rd_base_q),
        .rd_data(rd_data)
    );

`ifdef DMEM_PERF_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_commit && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (wr_commit && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed, table-driven bench for dmem_block_responder (default parameters,
// LATENCY=3) with hand-written reset-abort, wrap and back-to-back sequences.
module tb_dmem_block_responder;

    localparam int LAT = 3;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_rd;
    logic         req_wr;
    logic [31:0]  rd_addr;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic [127:0] rd_data;
    logic         rsp_valid;
    logic         busy;
    logic [15:0]  rd_cnt;
    logic [15:0]  wr_cnt;

    int checks;
    int errors;

    dmem_block_responder dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .rd_addr  (rd_addr),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rd_data  (rd_data),
        .rsp_valid(rsp_valid),
        .busy     (busy),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  ra;
        logic [31:0]  wa;
        logic [127:0] wd;
        int           lat;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [127:0] blk(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Issue one request; lat = edges after accept until rsp_valid is seen,
    // bsy = samples with req_ready low from accept through the response cycle.
    task automatic do_req(input logic rd_i, input logic wr_i, input logic [31:0] ra,
                          input logic [31:0] wa, input logic [127:0] wd,
                          output int lat, output int bsy, output bit got);
        @(negedge clk);
        req_rd    = rd_i;
        req_wr    = wr_i;
        rd_addr   = ra;
        wb_addr   = wa;
        wb_data   = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wb_data   = ~wd;
        rd_addr   = ra ^ 32'h0000_0050;
        wb_addr   = wa ^ 32'h0000_0030;
        req_rd    = ~rd_i;
        req_wr    = ~wr_i;
        lat = 0;
        bsy = (!req_ready) ? 1 : 0;
        got = rsp_valid;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!req_ready) bsy++;
            got = rsp_valid;
        end
    endtask

    int  lat;
    int  bsy;
    bit  got;
    int  edge_idx;
    int  rsp_edges[3];
    int  nrsp;
    int  ready_between;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        rd_addr   = '0;
        wb_addr   = '0;
        wb_data   = '0;

        vecs[0] = '{1'b0, 1'b1, 32'h0,    32'h40,  blk(32'hA0), LAT,     128'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h40,   32'h0,   128'h0,      LAT,     blk(32'hA0)};
        vecs[2] = '{1'b0, 1'b1, 32'h0,    32'h80,  blk(32'hD0), LAT,     blk(32'hA0)};
        vecs[3] = '{1'b1, 1'b0, 32'h8C,   32'h0,   128'h0,      LAT,     blk(32'hD0)};
        vecs[4] = '{1'b0, 1'b1, 32'h0,    32'h200, blk(32'hC0), LAT,     blk(32'hD0)};
        vecs[5] = '{1'b1, 1'b1, 32'h200,  32'h100, blk(32'hB0), 2 * LAT, blk(32'hC0)};
        vecs[6] = '{1'b1, 1'b0, 32'h100,  32'h0,   128'h0,      LAT,     blk(32'hB0)};
        vecs[7] = '{1'b1, 1'b1, 32'h100,  32'h100, blk(32'hF0), 2 * LAT, blk(32'hF0)};
        vecs[8] = '{1'b1, 1'b0, 32'h1040, 32'h0,   128'h0,      LAT,     blk(32'hA0)};
        vecs[9] = '{1'b0, 1'b0, 32'h0,    32'h0,   128'h0,      0,       blk(32'hA0)};

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_req_ready", req_ready, 1'b1);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_rsp_valid", rsp_valid, 1'b0);
        check_vec("reset_rd_data", rd_data, 128'h0);
        check_int("reset_rd_cnt", int'(rd_cnt), 0);
        check_int("reset_wr_cnt", int'(wr_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].ra, vecs[i].wa, vecs[i].wd, lat, bsy, got);
            check_bit($sformatf("vec%0d_rsp_seen", i), got, 1'b1);
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check_int($sformatf("vec%0d_busy_cycles", i), bsy, vecs[i].lat + 1);
            check_vec($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp);
            @(posedge clk);
            #1;
            check_bit($sformatf("vec%0d_rsp_one_cycle", i), rsp_valid, 1'b0);
            check_bit($sformatf("vec%0d_ready_after", i), req_ready, 1'b1);
        end

`ifdef DMEM_PERF_CNT_EN
        check_int("perf_rd_cnt_table", int'(rd_cnt), 6);
        check_int("perf_wr_cnt_table", int'(wr_cnt), 5);
`else
        check_int("perf_rd_cnt_table", int'(rd_cnt), 0);
        check_int("perf_wr_cnt_table", int'(wr_cnt), 0);
`endif

        // Reset in the middle of a writeback must abort it without touching the array.
        @(negedge clk);
        req_rd    = 1'b0;
        req_wr    = 1'b1;
        wb_addr   = 32'h40;
        wb_data   = blk(32'h90);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_bit("abort_rsp_valid", rsp_valid, 1'b0);
        check_bit("abort_ready_in_reset", req_ready, 1'b1);
        check_vec("abort_rd_data", rd_data, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_bit("abort_ready_after", req_ready, 1'b1);
        check_bit("abort_busy_after", busy, 1'b0);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 128'h0, lat, bsy, got);
        check_bit("abort_read_rsp", got, 1'b1);
        check_vec("abort_block_intact", rd_data, blk(32'hA0));

        // Back-to-back wrapped refills with req_valid held high.
        @(negedge clk);
        req_rd    = 1'b1;
        req_wr    = 1'b0;
        rd_addr   = 32'h1040;
        req_valid = 1'b1;
        edge_idx      = 0;
        nrsp          = 0;
        ready_between = 0;
        while (nrsp < 3 && edge_idx < 60) begin
            @(posedge clk);
            #1;
            edge_idx++;
            if (nrsp == 1 && req_ready) ready_between++;
            if (rsp_valid) begin
                rsp_edges[nrsp] = edge_idx;
                nrsp++;
            end
        end
        req_valid = 1'b0;
        check_int("b2b_rsp_count", nrsp, 3);
        check_int("b2b_gap0", rsp_edges[1] - rsp_edges[0], LAT + 2);
        check_int("b2b_gap1", rsp_edges[2] - rsp_edges[1], LAT + 2);
        check_int("b2b_idle_cycles", ready_between, 1);
        check_vec("b2b_rd_data", rd_data, blk(32'hA0));
        @(posedge clk);
        #1;
        check_bit("b2b_idle_after", req_ready, 1'b1);

`ifdef DMEM_PERF_CNT_EN
        check_int("perf_rd_cnt_after_reset", int'(rd_cnt), 4);
        check_int("perf_wr_cnt_after_reset", int'(wr_cnt), 0);
        force dut.rd_cnt_q = 16'hFFFF;
        force dut.wr_cnt_q = 16'hFFFF;
        #1;
        release dut.rd_cnt_q;
        release dut.wr_cnt_q;
        do_req(1'b1, 1'b1, 32'h40, 32'h300, blk(32'h55), lat, bsy, got);
        check_bit("perf_sat_rsp", got, 1'b1);
        check_int("perf_rd_cnt_sat", int'(rd_cnt), 16'hFFFF);
        check_int("perf_wr_cnt_sat", int'(wr_cnt), 16'hFFFF);
`else
        check_int("perf_rd_cnt_after_reset", int'(rd_cnt), 0);
        check_int("perf_wr_cnt_after_reset", int'(wr_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
